ram_burst_ctrl: RTL and testbench

//  Burst access sequencer that sits directly upstream of the single-port sync RAM (RAM_1).

---
 rtl/ram_burst_if.sv | 38 +++
 rtl/ram_burst_ctrl.sv | 133 +++++++++++++
 tb/tb_ram_burst_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_burst_if.sv
// Request, write-beat, read-return and RAM-side signals of the burst controller.
// slave = controller side, master = client/RAM environment side.
interface ram_burst_if #(
  parameter int ADD_SIZE  = 10,
  parameter int WORD_SIZE = 8,
  parameter int LEN_SIZE  = 4
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [ADD_SIZE-1:0]  req_addr;
  logic [LEN_SIZE-1:0]  req_len;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [WORD_SIZE-1:0] wr_data;
  logic                 rd_valid;
  logic [WORD_SIZE-1:0] rd_data;
  logic                 done;
  logic                 busy;
  logic                 ram_cs;
  logic                 ram_we;
  logic                 ram_re;
  logic [ADD_SIZE-1:0]  ram_addr;
  logic [WORD_SIZE-1:0] ram_din;
  logic [WORD_SIZE-1:0] ram_dout;

  modport slave (
    input  req_valid, req_write, req_addr, req_len, wr_valid, wr_data, ram_dout,
    output req_ready, wr_ready, rd_valid, rd_data, done, busy,
           ram_cs, ram_we, ram_re, ram_addr, ram_din
  );

  modport master (
    output req_valid, req_write, req_addr, req_len, wr_valid, wr_data, ram_dout,
    input  req_ready, wr_ready, rd_valid, rd_data, done, busy,
           ram_cs, ram_we, ram_re, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_burst_ctrl.sv
// Burst sequencer in front of a single-port sync RAM (1-cycle read latency).
// Optional RAM_CTRL_CLEAR_EN: zero-fill the whole RAM after reset before accepting requests.
module ram_burst_ctrl #(
  parameter int ADD_SIZE  = 10,
  parameter int WORD_SIZE = 8,
  parameter int LEN_SIZE  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  ram_burst_if.slave   bus
);

`ifdef RAM_CTRL_CLEAR_EN
  typedef enum logic [1:0] {IDLE, WRITE, READ, CLEAR} state_t;
  localparam state_t RST_STATE = CLEAR;
`else
  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  localparam state_t RST_STATE = IDLE;
`endif

  state_t               state, nxt;
  logic [ADD_SIZE-1:0]  cur_addr;
  logic [LEN_SIZE-1:0]  beats_left;
  logic                 rd_valid_q, done_q;
  logic                 beat, last, rd_issue;
  logic                 cs, we, re, req_rdy, wr_rdy;
  logic [ADD_SIZE-1:0]  addr;
  logic [WORD_SIZE-1:0] din;
`ifdef RAM_CTRL_CLEAR_EN
  // Holds off the first clear strobe until the cycle after reset release.
  logic                 clr_arm;
`endif

  always_comb begin
    nxt      = state;
    beat     = 1'b0;
    last     = 1'b0;
    rd_issue = 1'b0;
    cs       = 1'b0;
    we       = 1'b0;
    re       = 1'b0;
    addr     = '0;
    din      = '0;
    req_rdy  = 1'b0;
    wr_rdy   = 1'b0;
    case (state)
      IDLE: begin
        req_rdy = 1'b1;
        if (bus.req_valid) nxt = bus.req_write ? WRITE : READ;
      end
      WRITE: begin
        wr_rdy = 1'b1;
        if (bus.wr_valid) begin
          beat = 1'b1;
          cs   = 1'b1;
          we   = 1'b1;
          addr = cur_addr;
          din  = bus.wr_data;
          if (beats_left == '0) begin
            last = 1'b1;
            nxt  = IDLE;
          end
        end
      end
      READ: begin
        beat     = 1'b1;
        rd_issue = 1'b1;
        cs       = 1'b1;
        re       = 1'b1;
        addr     = cur_addr;
        if (beats_left == '0) begin
          last = 1'b1;
          nxt  = IDLE;
        end
      end
`ifdef RAM_CTRL_CLEAR_EN
      CLEAR: begin
        if (clr_arm) begin
          beat = 1'b1;
          cs   = 1'b1;
          we   = 1'b1;
          addr = cur_addr;
          if (&cur_addr) begin
            last = 1'b1;
            nxt  = IDLE;
          end
        end
      end
`endif
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RST_STATE;
      cur_addr   <= '0;
      beats_left <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef RAM_CTRL_CLEAR_EN
      clr_arm    <= 1'b0;
`endif
    end else begin
      state      <= nxt;
      rd_valid_q <= rd_issue;
      done_q     <= last;
`ifdef RAM_CTRL_CLEAR_EN
      clr_arm    <= 1'b1;
`endif
      if (state == IDLE && bus.req_valid) begin
        cur_addr   <= bus.req_addr;
        beats_left <= bus.req_len;
      end else if (beat) begin
        cur_addr   <= cur_addr + ADD_SIZE'(1);
        beats_left <= beats_left - LEN_SIZE'(1);
      end
    end
  end

  assign bus.req_ready = req_rdy;
  assign bus.wr_ready  = wr_rdy;
  assign bus.busy      = (state != IDLE);
  assign bus.ram_cs    = cs;
  assign bus.ram_we    = we;
  assign bus.ram_re    = re;
  assign bus.ram_addr  = addr;
  assign bus.ram_din   = din;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_valid_q ? bus.ram_dout : '0;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Scoreboard bench for ram_burst_ctrl with a behavioural sync RAM and shadow memory.
module tb_ram_burst_ctrl;
  localparam int A = 10, W = 8, L = 4, DEPTH = 1 << A;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_burst_if #(.ADD_SIZE(A), .WORD_SIZE(W), .LEN_SIZE(L)) bus ();
  ram_burst_ctrl #(.ADD_SIZE(A), .WORD_SIZE(W), .LEN_SIZE(L)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  logic [W-1:0] ram [DEPTH];
  logic [W-1:0] ram_q = '0;
  logic [W-1:0] shadow [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_cs && bus.ram_we) ram[bus.ram_addr] <= bus.ram_din;
    if (bus.ram_cs && bus.ram_re) ram_q <= ram[bus.ram_addr];
  end
  assign bus.ram_dout = ram_q;

  int n_tests = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [A+W-1:0] wq[$];
  logic [W-1:0]   rq[$];
  logic [A-1:0]   raq[$];
  int             rlen_q[$];
  int             rcur = 0;
  bit             clr_phase = 1'b0;
  int             clr_cnt = 0;
  logic [W-1:0]   wbuf [16];

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cs_rule", bus.ram_cs, bus.ram_we | bus.ram_re);
      if (bus.ram_cs) chk("we_re_excl", bus.ram_we & bus.ram_re, 0);
      if (bus.ram_cs && bus.ram_we) begin
        if (clr_phase) begin
          chk("clr_din", bus.ram_din, 0);
          chk("clr_addr", bus.ram_addr, clr_cnt[A-1:0]);
          clr_cnt++;
        end else if (wq.size() == 0) chk("wr_stray", 1, 0);
        else begin
          logic [A+W-1:0] e;
          e = wq.pop_front();
          chk("wr_addr", bus.ram_addr, e[A+W-1:W]);
          chk("wr_data", bus.ram_din, e[W-1:0]);
        end
      end
      if (bus.ram_cs && bus.ram_re) begin
        if (raq.size() == 0) chk("re_stray", 1, 0);
        else chk("rd_addr", bus.ram_addr, raq.pop_front());
      end
      if (bus.rd_valid) begin
        if (rq.size() == 0) chk("rd_stray", 1, 0);
        else begin
          chk("rd_data", bus.rd_data, rq.pop_front());
          if (rcur == 0 && rlen_q.size() != 0) rcur = rlen_q.pop_front();
          rcur--;
          chk("rd_done", bus.done, rcur == 0);
        end
      end
    end
  end

  task automatic wait_ready();
    int cyc = 0;
`ifdef RAM_CTRL_CLEAR_EN
    clr_phase = 1'b1;
    clr_cnt   = 0;
`endif
    while (!bus.req_ready && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("ready_timeout", bus.req_ready, 1);
`ifdef RAM_CTRL_CLEAR_EN
    clr_phase = 1'b0;
    chk("clr_count", clr_cnt, DEPTH);
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
`endif
  endtask

  task automatic wr_burst(input logic [A-1:0] a, input int n, input bit stall);
    int beat = 0, cyc = 0;
    chk("wr_req_ready", bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.req_write = 1'b1;
    bus.req_addr  = a;    bus.req_len   = L'(n - 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0;
    bus.req_addr  = ~a;   bus.req_len   = '1;
    while (beat < n && cyc < 200) begin
      bit v;
      v = stall ? (cyc % 3 == 0) : 1'b1;
      bus.wr_valid = v;
      bus.wr_data  = wbuf[beat];
      if (v) begin
        wq.push_back({A'(a + beat), wbuf[beat]});
        shadow[A'(a + beat)] = wbuf[beat];
        beat++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.wr_valid = 1'b0;
    chk("wr_done", bus.done, 1);
    chk("wr_idle", bus.req_ready, 1);
  endtask

  task automatic rd_burst(input logic [A-1:0] a, input int n);
    chk("rd_req_ready", bus.req_ready, 1);
    for (int i = 0; i < n; i++) begin
      rq.push_back(shadow[A'(a + i)]);
      raq.push_back(A'(a + i));
    end
    rlen_q.push_back(n);
    bus.req_valid = 1'b1; bus.req_write = 1'b0;
    bus.req_addr  = a;    bus.req_len   = L'(n - 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_write = 1'b1; bus.req_addr = ~a;
    repeat (n) @(posedge clk);
    #1;
    chk("rd_last_valid", bus.rd_valid, 1);
    chk("rd_idle", bus.busy, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]    = W'(i ^ 8'h5A);
      shadow[i] = W'(i ^ 8'h5A);
    end
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_len = '0; bus.wr_valid = 1'b0; bus.wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
`ifdef RAM_CTRL_CLEAR_EN
    chk("rst_req_ready", bus.req_ready, 0);
`else
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_busy", bus.busy, 0);
`endif
    chk("rst_cs", bus.ram_cs, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_done", bus.done, 0);
    rst_n = 1'b1;
    wait_ready();

    for (int i = 0; i < 4; i++) wbuf[i] = W'(8'hA0 + i);
    wr_burst(10'h010, 4, 1'b0);
    rd_burst(10'h010, 4);

    for (int i = 0; i < 4; i++) wbuf[i] = W'(8'hC0 + 3 * i);
    wr_burst(10'h3FE, 4, 1'b0);
    rd_burst(10'h3FE, 4);

    for (int i = 0; i < 6; i++) wbuf[i] = W'($urandom_range(0, 255));
    wr_burst(10'h100, 6, 1'b1);
    rd_burst(10'h100, 6);

    wbuf[0] = 8'h77;
    wr_burst(10'h3FF, 1, 1'b0);
    rd_burst(10'h3FF, 1);
    rd_burst(10'h3F8, 16);
    rd_burst(10'h200, 3);

    // Reset in the middle of an 8-beat read, after two beats were issued.
    for (int i = 0; i < 8; i++) begin
      rq.push_back(shadow[A'(10'h020 + i)]);
      raq.push_back(A'(10'h020 + i));
    end
    rlen_q.push_back(8);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 10'h020; bus.req_len = 4'd7;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs", bus.ram_cs, 0);
    chk("mid_rst_rd_valid", bus.rd_valid, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_busy_or_clr", bus.busy | bus.req_ready, 1);
    rq.delete(); raq.delete(); rlen_q.delete(); rcur = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready();
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_rd_valid", bus.rd_valid, 0);
    rd_burst(10'h020, 8);
    rd_burst(10'h010, 4);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", wq.size() + rq.size() + raq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
